// File: rtl/pu_pkg.sv
// Shared pu datapath definitions: default sizes, word/address types and the r0 constant.
// New code imports these in place of the old pu.vh width macros.
package pu_pkg;

   localparam int WIDTH_DEF = 16;
   localparam int NREG_DEF  = 4;
   localparam int CW_DEF    = 16;
   localparam int AW_DEF    = $clog2(NREG_DEF);

   typedef logic [WIDTH_DEF-1:0] word_t;
   typedef logic [AW_DEF-1:0]    regaddr_t;

   localparam regaddr_t R0 = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: tracks one outstanding writeback per register,
// accepts or refuses issue requests and reports read-port readiness to decode.
module rf_scoreboard
   import pu_pkg::*;
#(
   parameter int NREG    = NREG_DEF,
   parameter int AW      = $clog2(NREG),
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [AW-1:0] arad,
   input  logic [AW-1:0] brad,
   input  logic          we,
   input  logic [AW-1:0] wad,
   input  logic          iss,
   input  logic [AW-1:0] iad,
   output logic          a_rdy,
   output logic          b_rdy,
   output logic          iss_ok
);

   localparam bit ZR = (ZERO_R0 != 0);
   localparam bit BP = (BYPASS != 0);

   logic [NREG-1:0] busy_q, busy_d;

   always_comb begin
      a_rdy = !busy_q[arad];
      if (BP && we && (wad == arad)) a_rdy = 1'b1;
      if (ZR && (arad == AW'(R0)))   a_rdy = 1'b1;
      if (rst)                       a_rdy = 1'b1;

      b_rdy = !busy_q[brad];
      if (BP && we && (wad == brad)) b_rdy = 1'b1;
      if (ZR && (brad == AW'(R0)))   b_rdy = 1'b1;
      if (rst)                       b_rdy = 1'b1;

      // A register being written back this cycle frees its slot for the new issue.
      iss_ok = iss && (!busy_q[iad] || (we && (wad == iad)));
      if (ZR && (iad == AW'(R0))) iss_ok = iss;
      if (rst)                    iss_ok = iss;

      busy_d = busy_q;
      if (we) busy_d[wad] = 1'b0;
      if (iss_ok && !(ZR && (iad == AW'(R0)))) busy_d[iad] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy_q <= '0;
      else     busy_q <= busy_d;
   end

endmodule

// File: rtl/regfile_sb.sv
// Parametrised pu register file with write-to-read bypass, optional hardwired r0,
// a busy scoreboard for hazard detection and a clearable event counter.
module regfile_sb
   import pu_pkg::*;
#(
   parameter int WIDTH   = WIDTH_DEF,
   parameter int NREG    = NREG_DEF,
   parameter int AW      = $clog2(NREG),
   parameter int CW      = CW_DEF,
   parameter int ZERO_R0 = 0,
   parameter int BYPASS  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    arad,
   input  logic [AW-1:0]    brad,
   output logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] b,
   output logic             a_rdy,
   output logic             b_rdy,
   input  logic             we,
   input  logic [AW-1:0]    wad,
   input  logic [WIDTH-1:0] wd,
   input  logic             iss,
   input  logic [AW-1:0]    iad,
   output logic             iss_ok,
   input  logic             cwe,
   input  logic             cclr,
   output logic [CW-1:0]    c,
   output logic             c_ovf
);

   localparam bit ZR = (ZERO_R0 != 0);
   localparam bit BP = (BYPASS != 0);

   logic [WIDTH-1:0] regs_q [NREG];
   logic [CW-1:0]    c_q, c_d;
   logic             ovf_q, ovf_d;
   logic             wr_en;

   assign wr_en = we && !(ZR && (wad == AW'(R0)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (wr_en) begin
         regs_q[wad] <= wd;
      end
   end

   // r0 forcing sits after the bypass so a dropped r0 write is never forwarded.
   always_comb begin
      a = regs_q[arad];
      if (BP && we && (wad == arad)) a = wd;
      if (ZR && (arad == AW'(R0)))   a = '0;
      if (rst)                       a = '0;

      b = regs_q[brad];
      if (BP && we && (wad == brad)) b = wd;
      if (ZR && (brad == AW'(R0)))   b = '0;
      if (rst)                       b = '0;
   end

   always_comb begin
      c_d   = c_q;
      ovf_d = ovf_q;
      if (cclr) begin
         c_d   = '0;
         ovf_d = 1'b0;
      end else if (cwe) begin
         c_d = c_q + CW'(1);
         if (c_q == '1) ovf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         c_q   <= '0;
         ovf_q <= 1'b0;
      end else begin
         c_q   <= c_d;
         ovf_q <= ovf_d;
      end
   end

   assign c     = c_q;
   assign c_ovf = ovf_q;

   rf_scoreboard #(
      .NREG    (NREG),
      .AW      (AW),
      .ZERO_R0 (ZERO_R0),
      .BYPASS  (BYPASS)
   ) u_sb (
      .clk    (clk),
      .rst    (rst),
      .arad   (arad),
      .brad   (brad),
      .we     (we),
      .wad    (wad),
      .iss    (iss),
      .iad    (iad),
      .a_rdy  (a_rdy),
      .b_rdy  (b_rdy),
      .iss_ok (iss_ok)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two configurations (bypass/no-r0, no-bypass/zero-r0) driven in
// parallel, checked against an array-based model every cycle plus literal spot checks.
module tb_regfile_sb;

   logic        clk = 1'b0, run = 1'b0, rst = 1'b0, cmp_en = 1'b0;
   logic [1:0]  arad = '0, brad = '0, wad = '0, iad = '0;
   logic        we = 1'b0, iss = 1'b0, cwe = 1'b0, cclr = 1'b0;
   logic [15:0] wd = '0;

   logic [15:0] a0, b0, a1, b1;
   logic        ar0, br0, ok0, v0, ar1, br1, ok1, v1;
   logic [3:0]  c0;
   logic [4:0]  c1;

   int n_chk = 0, n_fail = 0;

   always #5 if (run) clk = ~clk;

   regfile_sb #(.WIDTH(16), .NREG(4), .CW(4), .ZERO_R0(0), .BYPASS(1)) dut0 (
      .clk(clk), .rst(rst), .arad(arad), .brad(brad), .a(a0), .b(b0),
      .a_rdy(ar0), .b_rdy(br0), .we(we), .wad(wad), .wd(wd), .iss(iss),
      .iad(iad), .iss_ok(ok0), .cwe(cwe), .cclr(cclr), .c(c0), .c_ovf(v0));

   regfile_sb #(.WIDTH(16), .NREG(4), .CW(5), .ZERO_R0(1), .BYPASS(0)) dut1 (
      .clk(clk), .rst(rst), .arad(arad), .brad(brad), .a(a1), .b(b1),
      .a_rdy(ar1), .b_rdy(br1), .we(we), .wad(wad), .wd(wd), .iss(iss),
      .iad(iad), .iss_ok(ok1), .cwe(cwe), .cclr(cclr), .c(c1), .c_ovf(v1));

   // Reference model: register contents, pending set and counter per configuration.
   logic [15:0] m_reg  [2][4];
   bit          m_busy [2][4];
   int          m_c    [2];
   bit          m_ovf  [2];
   int          cw_k   [2] = '{4, 5};
   bit          z_k    [2] = '{1'b0, 1'b1};
   bit          bp_k   [2] = '{1'b1, 1'b0};

   function automatic logic [15:0] e_rd(int k, logic [1:0] ad);
      if (rst) return '0;
      if (z_k[k] && ad == 2'd0) return '0;
      if (bp_k[k] && we && wad == ad) return wd;
      return m_reg[k][ad];
   endfunction

   function automatic bit e_rdy(int k, logic [1:0] ad);
      if (rst) return 1'b1;
      if (z_k[k] && ad == 2'd0) return 1'b1;
      if (bp_k[k] && we && wad == ad) return 1'b1;
      return !m_busy[k][ad];
   endfunction

   function automatic bit e_ok(int k);
      if (rst) return iss;
      if (z_k[k] && iad == 2'd0) return iss;
      return iss && (!m_busy[k][iad] || (we && wad == iad));
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 4; i++) begin
               m_reg[k][i]  <= '0;
               m_busy[k][i] <= 1'b0;
            end
            m_c[k]   <= 0;
            m_ovf[k] <= 1'b0;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (we && !(z_k[k] && wad == 2'd0)) m_reg[k][wad] <= wd;
            if (we) m_busy[k][wad] <= 1'b0;
            if (e_ok(k) && !(z_k[k] && iad == 2'd0)) m_busy[k][iad] <= 1'b1;
            if (cclr) begin
               m_c[k]   <= 0;
               m_ovf[k] <= 1'b0;
            end else if (cwe) begin
               m_c[k] <= (m_c[k] + 1) % (1 << cw_k[k]);
               if (m_c[k] + 1 == (1 << cw_k[k])) m_ovf[k] <= 1'b1;
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("a0",   32'(a0),  32'(e_rd(0, arad)));
         chk("b0",   32'(b0),  32'(e_rd(0, brad)));
         chk("ardy0",32'(ar0), 32'(e_rdy(0, arad)));
         chk("brdy0",32'(br0), 32'(e_rdy(0, brad)));
         chk("ok0",  32'(ok0), 32'(e_ok(0)));
         chk("c0",   32'(c0),  32'(m_c[0]));
         chk("ovf0", 32'(v0),  32'(m_ovf[0]));
         chk("a1",   32'(a1),  32'(e_rd(1, arad)));
         chk("b1",   32'(b1),  32'(e_rd(1, brad)));
         chk("ardy1",32'(ar1), 32'(e_rdy(1, arad)));
         chk("brdy1",32'(br1), 32'(e_rdy(1, brad)));
         chk("ok1",  32'(ok1), 32'(e_ok(1)));
         chk("c1",   32'(c1),  32'(m_c[1]));
         chk("ovf1", 32'(v1),  32'(m_ovf[1]));
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // reset with the clock stopped
      #1 rst = 1'b1; iss = 1'b1; iad = 2'd1;
      #1;
      chk("rst_a0", 32'(a0), 'h0);
      chk("rst_b0", 32'(b0), 'h0);
      chk("rst_c0", 32'(c0), 'h0);
      chk("rst_ovf0", 32'(v0), 'h0);
      chk("rst_ardy0", 32'(ar0), 'h1);
      chk("rst_brdy0", 32'(br0), 'h1);
      chk("rst_ok0", 32'(ok0), 'h1);
      chk("rst_ok1", 32'(ok1), 'h1);
      rst = 1'b0; iss = 1'b0; iad = 2'd0;
      #1 run = 1'b1; cmp_en = 1'b1;

      // write with and without bypass
      cyc();
      we = 1'b1; wad = 2'd3; wd = 16'hBEEF; arad = 2'd3;
      #1;
      chk("byp_a0", 32'(a0), 'hBEEF);
      chk("nobyp_a1", 32'(a1), 'h0);
      cyc();
      we = 1'b0;
      #1;
      chk("after_a0", 32'(a0), 'hBEEF);
      chk("after_a1", 32'(a1), 'hBEEF);

      // reset mid-cycle wipes a committed write
      cyc();
      we = 1'b1; wad = 2'd2; wd = 16'h1234;
      cyc();
      we = 1'b0; arad = 2'd2;
      #1 chk("wr_a0", 32'(a0), 'h1234);
      #1 rst = 1'b1;
      #1;
      chk("midrst_a0", 32'(a0), 'h0);
      chk("midrst_a1", 32'(a1), 'h0);
      rst = 1'b0;

      // scoreboard hazards
      cyc();
      iss = 1'b1; iad = 2'd1;
      #1;
      chk("iss_ok0", 32'(ok0), 'h1);
      chk("iss_ok1", 32'(ok1), 'h1);
      cyc();
      arad = 2'd1;
      #1;
      chk("busy_ardy0", 32'(ar0), 'h0);
      chk("busy_ardy1", 32'(ar1), 'h0);
      chk("waw_ok0", 32'(ok0), 'h0);
      chk("waw_ok1", 32'(ok1), 'h0);
      cyc();
      we = 1'b1; wad = 2'd1; wd = 16'h0055;
      #1;
      chk("wbiss_ok0", 32'(ok0), 'h1);
      chk("wbiss_ok1", 32'(ok1), 'h1);
      chk("wbbyp_ardy0", 32'(ar0), 'h1);
      chk("wbnobyp_ardy1", 32'(ar1), 'h0);
      cyc();
      we = 1'b0; iss = 1'b0;
      #1;
      chk("r1_a0", 32'(a0), 'h55);
      chk("r1_a1", 32'(a1), 'h55);
      chk("rebusy_ardy0", 32'(ar0), 'h0);
      chk("rebusy_ardy1", 32'(ar1), 'h0);
      cyc();
      we = 1'b1; wad = 2'd1;
      cyc();
      we = 1'b0;
      #1;
      chk("free_ardy0", 32'(ar0), 'h1);
      chk("free_ardy1", 32'(ar1), 'h1);

      // hardwired r0
      cyc();
      we = 1'b1; wad = 2'd0; wd = 16'hFFFF;
      cyc();
      we = 1'b0; arad = 2'd0; iss = 1'b1; iad = 2'd0;
      #1;
      chk("r0_a1", 32'(a1), 'h0);
      chk("r0_a0", 32'(a0), 'hFFFF);
      chk("r0_ok1", 32'(ok1), 'h1);
      cyc();
      iss = 1'b0;
      #1;
      chk("r0_ardy1", 32'(ar1), 'h1);
      chk("r0_ardy0", 32'(ar0), 'h0);
      cyc();
      we = 1'b1; wad = 2'd0;
      cyc();
      we = 1'b0;

      // counter wrap and clear
      cclr = 1'b1;
      cyc();
      cclr = 1'b0; cwe = 1'b1;
      repeat (15) cyc();
      #1;
      chk("cnt15_c0", 32'(c0), 'd15);
      chk("cnt15_ovf0", 32'(v0), 'h0);
      cyc();
      #1;
      chk("wrap_c0", 32'(c0), 'h0);
      chk("wrap_ovf0", 32'(v0), 'h1);
      chk("cnt16_c1", 32'(c1), 'd16);
      chk("cnt16_ovf1", 32'(v1), 'h0);
      cclr = 1'b1;
      cyc();
      cwe = 1'b0; cclr = 1'b0;
      #1;
      chk("clr_c0", 32'(c0), 'h0);
      chk("clr_ovf0", 32'(v0), 'h0);
      chk("clr_c1", 32'(c1), 'h0);

      // dual read of one register
      cyc();
      we = 1'b1; wad = 2'd2; wd = 16'h00A5;
      cyc();
      we = 1'b0; arad = 2'd2; brad = 2'd2; iss = 1'b1; iad = 2'd2;
      #1;
      chk("dual_a0", 32'(a0), 'hA5);
      chk("dual_b0", 32'(b0), 'hA5);
      chk("dual_a1", 32'(a1), 'hA5);
      chk("dual_b1", 32'(b1), 'hA5);
      chk("dual_brdy0", 32'(br0), 'h1);
      cyc();
      iss = 1'b0;
      #1;
      chk("dual_busy_ardy0", 32'(ar0), 'h0);
      chk("dual_busy_brdy0", 32'(br0), 'h0);
      chk("dual_busy_brdy1", 32'(br1), 'h0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         cyc();
         arad = 2'($urandom_range(0, 3));
         brad = 2'($urandom_range(0, 3));
         wad  = 2'($urandom_range(0, 3));
         iad  = 2'($urandom_range(0, 3));
         wd   = 16'($urandom);
         we   = ($urandom_range(0, 1) == 1);
         iss  = ($urandom_range(0, 1) == 1);
         cwe  = ($urandom_range(0, 9) < 7);
         cclr = ($urandom_range(0, 39) == 0);
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1'b1;
            #1 rst = 1'b0;
         end
      end

      cyc();
      cmp_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
